wb_stage_pipe: RTL and testbench

//  Registered, parametrised writeback stage. Accepts one retiring instruction per cycle from MEM,

---
 rtl/wb_stage_pipe_if.sv | 44 ++++
 rtl/wb_stage_pipe.sv | 138 +++++++++++++
 tb/tb_wb_stage_pipe.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pipe_if.sv
// Writeback-stage bundle: MEM-side retire bus, late memory data, and RF write/hazard outputs.
// Pure wiring, no latency of its own.
// The master drives in_valid and is held off by in_ready; the slave is the writeback stage.
interface wb_stage_pipe_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    localparam int OFF_W = $clog2(XLEN / 8);

    // retire handshake from MEM
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            ctrl_wb;
    logic [2:0]            ld_funct3;
    logic [OFF_W-1:0]      byte_off;
    logic [XLEN-1:0]       pc4_wb;
    logic [XLEN-1:0]       alu_data;
    logic [REG_ADDR_W-1:0] rd_wb;

    // memory return, may arrive after the handshake
    logic                  mem_valid;
    logic [XLEN-1:0]       mem_data;

    // register-file write port
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]       rf_wdata;

    // hazard-unit view of an outstanding load
    logic                  ld_pending;
    logic [REG_ADDR_W-1:0] ld_pend_rd;

    modport master (
        output in_valid, ctrl_wb, ld_funct3, byte_off, pc4_wb, alu_data, rd_wb,
        output mem_valid, mem_data,
        input  in_ready, rf_we, rf_waddr, rf_wdata, ld_pending, ld_pend_rd
    );

    modport slave (
        input  in_valid, ctrl_wb, ld_funct3, byte_off, pc4_wb, alu_data, rd_wb,
        input  mem_valid, mem_data,
        output in_ready, rf_we, rf_waddr, rf_wdata, ld_pending, ld_pend_rd
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// Writeback stage: selects ALU / load / PC+4 result, formats load data, drives the RF write port.
// Latency 1 cycle from handshake (or from mem_valid for a late load); throughput 1 per cycle.
// in_ready drops while a load waits for its memory data; it returns on the cycle of the write.
module wb_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_stage_pipe_if.slave   bus
);
    // Derived from XLEN only; the interface computes the same width for byte_off.
    localparam int OFF_W = $clog2(XLEN / 8);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t                state;

    // Context of a load whose data has not yet come back.
    logic [REG_ADDR_W-1:0] lat_rd;
    logic [2:0]            lat_f3;
    logic [OFF_W-1:0]      lat_off;
    logic                  lat_we;

    // Registered RF write port.
    logic                  we_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]       wdata_q;

    logic                  is_load;
    logic                  handshake;
    logic [XLEN-1:0]       sel_data;

    // Extract and extend a load from the raw aligned memory word. Lanes are
    // little-endian; halfword/word offsets are forced to natural alignment so
    // misaligned low bits are simply ignored.
    function automatic logic [XLEN-1:0] fmt_load(
        input logic [2:0]       f3,
        input logic [OFF_W-1:0] off,
        input logic [XLEN-1:0]  word
    );
        logic [OFF_W-1:0] off_h;
        logic [OFF_W-1:0] off_w;
        logic [XLEN-1:0]  sb;
        logic [XLEN-1:0]  sh;
        logic [XLEN-1:0]  sw;
        logic [XLEN-1:0]  r;
        off_h = off & ~OFF_W'(1);
        off_w = off & ~OFF_W'(3);
        sb    = word >> {off,   3'b000};
        sh    = word >> {off_h, 3'b000};
        sw    = word >> {off_w, 3'b000};
        case (f3)
            3'b000:  r = XLEN'($signed(sb[7:0]));
            3'b100:  r = XLEN'(sb[7:0]);
            3'b001:  r = XLEN'($signed(sh[15:0]));
            3'b101:  r = XLEN'(sh[15:0]);
            // At XLEN=32 both of these collapse to the full word.
            3'b010:  r = XLEN'($signed(sw[31:0]));
            3'b110:  r = XLEN'(sw[31:0]);
            // LD, and the reserved encodings, pass the word through.
            default: r = word;
        endcase
        return r;
    endfunction

    assign is_load   = (bus.ctrl_wb[1:0] == 2'b01);
    assign handshake = bus.in_valid & (state == IDLE);

    // Result mux for an instruction that retires in the handshake cycle.
    always_comb begin
        sel_data = bus.alu_data;
        if (bus.ctrl_wb[1]) begin
            sel_data = bus.pc4_wb;
        end else if (bus.ctrl_wb[0]) begin
            sel_data = fmt_load(bus.ld_funct3, bus.byte_off, bus.mem_data);
        end
    end

    // FSM plus registered write port; the write strobe is a one-cycle pulse,
    // address/data hold their last value when nothing retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            lat_rd  <= '0;
            lat_f3  <= '0;
            lat_off <= '0;
            lat_we  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (is_load && !bus.mem_valid) begin
                            lat_rd  <= bus.rd_wb;
                            lat_f3  <= bus.ld_funct3;
                            lat_off <= bus.byte_off;
                            lat_we  <= bus.ctrl_wb[2];
                            state   <= WAIT_MEM;
                        end else begin
                            // x0 is hardwired: never strobe a write to it.
                            we_q    <= bus.ctrl_wb[2] & (bus.rd_wb != '0);
                            waddr_q <= bus.rd_wb;
                            wdata_q <= sel_data;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_valid) begin
                        we_q    <= lat_we & (lat_rd != '0);
                        waddr_q <= lat_rd;
                        wdata_q <= fmt_load(lat_f3, lat_off, bus.mem_data);
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and hazard outputs follow directly from the registered state.
    always_comb begin
        bus.in_ready   = (state == IDLE);
        bus.ld_pending = (state == WAIT_MEM);
        bus.ld_pend_rd = (state == WAIT_MEM) ? lat_rd : '0;
        bus.rf_we      = we_q;
        bus.rf_waddr   = waddr_q;
        bus.rf_wdata   = wdata_q;
    end
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe at XLEN=32.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
module tb_wb_stage_pipe;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    wb_stage_pipe_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

    wb_stage_pipe #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] ctrl, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] pc4, input logic [31:0] alu,
                         input logic [4:0] rd, input logic mv, input logic [31:0] md);
        bus.in_valid  = v;
        bus.ctrl_wb   = ctrl;
        bus.ld_funct3 = f3;
        bus.byte_off  = off;
        bus.pc4_wb    = pc4;
        bus.alu_data  = alu;
        bus.rd_wb     = rd;
        bus.mem_valid = mv;
        bus.mem_data  = md;
    endtask

    task automatic idle_in();
        drive(1'b0, 3'b000, 3'b000, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        check({tag, ".we"},    bus.rf_we,    we);
        check({tag, ".waddr"}, bus.rf_waddr, wa);
        check({tag, ".wdata"}, bus.rf_wdata, wd);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle_in();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_wr("reset", 1'b0, 5'd0, 32'h0);
        check("reset.ld_pending", bus.ld_pending, 1'b0);
        check("reset.ld_pend_rd", bus.ld_pend_rd, 5'd0);
        #2 rst_n = 1'b1;
        #1;
        check("reset.in_ready", bus.in_ready, 1'b1);
        step();

        // ALU result
        drive(1'b1, 3'b100, 3'b000, 2'd0, 32'h0, 32'h1234, 5'd5, 1'b0, 32'h0);
        step();
        check_wr("alu", 1'b1, 5'd5, 32'h1234);

        // JAL writes PC+4; rd=0 suppresses the strobe
        drive(1'b1, 3'b110, 3'b000, 2'd0, 32'h104, 32'hDEAD, 5'd1, 1'b0, 32'h0);
        step();
        check_wr("jal", 1'b1, 5'd1, 32'h104);
        drive(1'b1, 3'b110, 3'b000, 2'd0, 32'h108, 32'hDEAD, 5'd0, 1'b0, 32'h0);
        step();
        check("jal_x0.we", bus.rf_we, 1'b0);

        // LB / LBU, data same cycle, byte 3 = 0x80
        drive(1'b1, 3'b101, 3'b000, 2'd3, 32'h0, 32'h0, 5'd4, 1'b1, 32'h80FF_0000);
        step();
        check_wr("lb", 1'b1, 5'd4, 32'hFFFF_FF80);
        check("lb.in_ready", bus.in_ready, 1'b1);
        drive(1'b1, 3'b101, 3'b100, 2'd3, 32'h0, 32'h0, 5'd4, 1'b1, 32'h80FF_0000);
        step();
        check_wr("lbu", 1'b1, 5'd4, 32'h0000_0080);

        // LHU on the upper half, LB on byte 1
        drive(1'b1, 3'b101, 3'b101, 2'd3, 32'h0, 32'h0, 5'd6, 1'b1, 32'h8001_7F00);
        step();
        check_wr("lhu", 1'b1, 5'd6, 32'h0000_8001);
        drive(1'b1, 3'b101, 3'b000, 2'd1, 32'h0, 32'h0, 5'd6, 1'b1, 32'h8001_7F00);
        step();
        check_wr("lb_b1", 1'b1, 5'd6, 32'h0000_007F);

        // No handshake: strobe drops, address and data hold
        idle_in();
        step();
        check_wr("idle", 1'b0, 5'd6, 32'h0000_007F);

        // LH with late data; a following ALU op waits on in_ready
        drive(1'b1, 3'b101, 3'b001, 2'd2, 32'h0, 32'h0, 5'd7, 1'b0, 32'h0);
        step();
        drive(1'b1, 3'b100, 3'b000, 2'd0, 32'h0, 32'h55, 5'd9, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("lh_wait.in_ready",   bus.in_ready,   1'b0);
            check("lh_wait.ld_pending", bus.ld_pending, 1'b1);
            check("lh_wait.ld_pend_rd", bus.ld_pend_rd, 5'd7);
            check("lh_wait.we",         bus.rf_we,      1'b0);
            if (i == 2) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = 32'h8001_0000;
            end
            step();
        end
        check_wr("lh_late", 1'b1, 5'd7, 32'hFFFF_8001);
        check("lh_late.in_ready",   bus.in_ready,   1'b1);
        check("lh_late.ld_pending", bus.ld_pending, 1'b0);
        check("lh_late.ld_pend_rd", bus.ld_pend_rd, 5'd0);

        // Held ALU op now accepted; stray mem_valid in IDLE is ignored
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'hFFFF_FFFF;
        step();
        check_wr("after_stall", 1'b1, 5'd9, 32'h55);
        check("after_stall.in_ready", bus.in_ready, 1'b1);

        // Four back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b100, 3'b000, 2'd0, 32'h0, 32'hA0 + 32'(i), 5'(10 + i), 1'b0, 32'h0);
            step();
            check_wr("b2b", 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
        end
        idle_in();
        step();
        check("b2b_end.we", bus.rf_we, 1'b0);

        // Late LW to x0: stalls, consumes mem_valid, never writes
        drive(1'b1, 3'b101, 3'b010, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        step();
        idle_in();
        check("lw_x0.ld_pending", bus.ld_pending, 1'b1);
        check("lw_x0.ld_pend_rd", bus.ld_pend_rd, 5'd0);
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'h1357_9BDF;
        step();
        bus.mem_valid = 1'b0;
        check("lw_x0.we",       bus.rf_we,    1'b0);
        check("lw_x0.in_ready", bus.in_ready, 1'b1);

        // Reset while waiting for load data
        drive(1'b1, 3'b101, 3'b010, 2'd0, 32'h0, 32'h0, 5'd3, 1'b0, 32'h0);
        step();
        idle_in();
        check("rst_wait.ld_pending", bus.ld_pending, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_wr("rst_wait", 1'b0, 5'd0, 32'h0);
        check("rst_wait.ld_pending", bus.ld_pending, 1'b0);
        check("rst_wait.ld_pend_rd", bus.ld_pend_rd, 5'd0);
        step();
        rst_n = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'hCAFE_F00D;
        step();
        bus.mem_valid = 1'b0;
        check_wr("rst_discard", 1'b0, 5'd0, 32'h0);
        check("rst_discard.in_ready", bus.in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
